// File: rtl/divpoly_loader_if.sv
// divpoly_loader_if: source-read, operand-write and status bus of the polynomial loader
interface divpoly_loader_if #(parameter int AW = 11, parameter int DW = 13);
    logic          start;
    logic [11:0]   modu;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_data;
    logic          dst_we;
    logic          busy;
    logic          done;
    logic [AW-1:0] deg;
    logic [DW-1:0] lead_coef;
    logic          zero_poly;
    modport master (
        input  start, modu, src_data,
        output src_addr, dst_addr, dst_data, dst_we, busy, done, deg, lead_coef, zero_poly
    );
    modport slave (
        output start, modu, src_data,
        input  src_addr, dst_addr, dst_data, dst_we, busy, done, deg, lead_coef, zero_poly
    );
endinterface

// File: rtl/divpoly_loader.sv
// divpoly_loader: streams one polynomial, reduces each coefficient into [0,modu) and tracks degree
module divpoly_loader #(
    parameter int N_COEF = 757,
    parameter int AW     = 11,
    parameter int DW     = 13
) (
    input logic clk,
    input logic rst,
    divpoly_loader_if.master bus
);
    localparam int XW = DW + 1;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state, state_nx;
    logic last;
    logic signed [XW-1:0] x, m, red;
    assign last = bus.src_addr == AW'(N_COEF - 1);
    // one extra bit keeps x+modu and x-modu free of overflow
    assign x   = XW'($signed(bus.src_data));
    assign m   = XW'(bus.modu);
    assign red = x < 0 ? x + m : x >= m ? x - m : x;
    assign bus.dst_data = bus.dst_we ? red[DW-1:0] : '0;
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;
    always_comb begin
        state_nx = (state == IDLE && bus.start) ? RUN :
                   (state == RUN && last)       ? FLUSH :
                   state == FLUSH               ? DONE :
                   state == DONE                ? IDLE : state;
        bus.busy = state != IDLE;
        bus.done = state == DONE;
    end
    // write address trails the read address by one cycle to match RAM latency
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.src_addr  <= '0;
            bus.dst_addr  <= '0;
            bus.dst_we    <= 1'b0;
            bus.deg       <= '0;
            bus.lead_coef <= '0;
            bus.zero_poly <= 1'b0;
        end else begin
            bus.src_addr <= (state == RUN && !last) ? bus.src_addr + AW'(1) : '0;
            bus.dst_addr <= bus.src_addr;
            bus.dst_we   <= state == RUN;
            if (state == IDLE && bus.start) begin
                bus.deg       <= '0;
                bus.lead_coef <= '0;
                bus.zero_poly <= 1'b1;
            end else if (bus.dst_we && red != '0) begin
                bus.deg       <= bus.dst_addr;
                bus.lead_coef <= red[DW-1:0];
                bus.zero_poly <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_divpoly_loader.sv
// tb_divpoly_loader: directed vectors with hand-computed reductions, degree and timing checks
module tb_divpoly_loader;
    localparam int N = 757;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    divpoly_loader_if #(.AW(11), .DW(13)) bus();
    divpoly_loader dut (.clk(clk), .rst(rst), .bus(bus));
    logic [12:0] smem [N];
    logic [12:0] dmem [N];
    logic [12:0] emem [N];
    int total = 0;
    int bad = 0;
    int nwr, nbadord, nrng, ndone, wexp;
    int e_deg, e_lead, e_zp;
    logic clr = 1'b0;

    always @(posedge clk) bus.src_data <= smem[bus.src_addr];

    always @(negedge clk) begin
        if (clr) begin
            nwr = 0; nbadord = 0; nrng = 0; ndone = 0; wexp = 0;
            for (int i = 0; i < N; i++) dmem[i] = 13'h1555;
        end else begin
            if (bus.dst_we) begin
                if (int'(bus.dst_addr) != wexp) nbadord++;
                if (bus.dst_data >= 13'(bus.modu)) nrng++;
                dmem[bus.dst_addr] = bus.dst_data;
                wexp++;
                nwr++;
            end
            if (bus.done) ndone++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_src(input int md);
        bus.modu = 12'(md);
        for (int i = 0; i < N; i++) begin
            smem[i] = '0;
            emem[i] = '0;
        end
    endtask

    task automatic run_job(input int p1, input int p2, input int rst_at);
        int done_at = 0;
        int nmis = 0;
        @(posedge clk); #1 clr = 1'b1;
        @(negedge clk); #1 clr = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int n = 1; n <= 900; n++) begin
            if (n == 1) begin
                chk("busy1", int'(bus.busy), 1);
                chk("saddr1", int'(bus.src_addr), 0);
                chk("we1", int'(bus.dst_we), 0);
            end
            if (n == 6) begin
                chk("saddr6", int'(bus.src_addr), 5);
                chk("daddr6", int'(bus.dst_addr), 4);
                chk("we6", int'(bus.dst_we), 1);
            end
            if (rst_at > 0 && n == rst_at + 1) begin
                chk("rst_busy", int'(bus.busy), 0);
                chk("rst_outs", int'(bus.src_addr) + int'(bus.dst_addr) + int'(bus.dst_data)
                    + int'(bus.dst_we) + int'(bus.done) + int'(bus.deg) + int'(bus.lead_coef)
                    + int'(bus.zero_poly), 0);
                rst = 1'b0;
            end
            if (done_at > 0 && n == done_at + 1) begin
                chk("busy_end", int'(bus.busy), 0);
                chk("done_end", int'(bus.done), 0);
                break;
            end
            if (bus.done && done_at == 0) done_at = n;
            bus.start = (n == p1 || n == p2);
            if (n == rst_at) rst = 1'b1;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        if (rst_at > 0) begin
            chk("rst_nodone", ndone, 0);
        end else begin
            chk("done_cyc", done_at, N + 2);
            chk("ndone", ndone, 1);
            chk("nwr", nwr, N);
            chk("order", nbadord, 0);
            chk("range", nrng, 0);
            for (int i = 0; i < N; i++) if (dmem[i] != emem[i]) nmis++;
            chk("dst_words", nmis, 0);
            chk("dst0", int'(dmem[0]), int'(emem[0]));
            chk("dst756", int'(dmem[756]), int'(emem[756]));
            repeat (3) @(posedge clk);
            #1;
            chk("deg", int'(bus.deg), e_deg);
            chk("lead", int'(bus.lead_coef), e_lead);
            chk("zero", int'(bus.zero_poly), e_zp);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.modu = 12'd3329;
        for (int i = 0; i < N; i++) smem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_outs", int'(bus.src_addr) + int'(bus.dst_addr) + int'(bus.dst_data)
            + int'(bus.dst_we) + int'(bus.done) + int'(bus.deg) + int'(bus.lead_coef)
            + int'(bus.zero_poly), 0);
        rst = 1'b0;

        clr_src(3329);
        smem[0] = 13'd1; emem[0] = 13'd1;
        smem[1] = 13'd2; emem[1] = 13'd2;
        e_deg = 1; e_lead = 2; e_zp = 0;
        run_job(0, 0, 0);

        clr_src(3329);
        smem[0] = 13'd8191; emem[0] = 13'd3328;
        smem[756] = 13'd3330; emem[756] = 13'd1;
        e_deg = 756; e_lead = 1; e_zp = 0;
        run_job(0, 0, 0);

        clr_src(3329);
        for (int i = 0; i < N; i++) smem[i] = (i % 2 == 1) ? 13'd3329 : 13'd0;
        e_deg = 0; e_lead = 0; e_zp = 1;
        run_job(0, 0, 0);

        clr_src(3329);
        smem[10] = 13'd4863;
        smem[5] = 13'd7; emem[5] = 13'd7;
        smem[3] = 13'd3328; emem[3] = 13'd3328;
        e_deg = 5; e_lead = 7; e_zp = 0;
        run_job(0, 0, 0);

        clr_src(4095);
        smem[0] = 13'd8191; emem[0] = 13'd4094;
        smem[1] = 13'd4094; emem[1] = 13'd4094;
        smem[2] = 13'd4097;
        smem[3] = 13'd4095;
        e_deg = 1; e_lead = 4094; e_zp = 0;
        run_job(0, 0, 0);

        clr_src(2);
        smem[0] = 13'd3; emem[0] = 13'd1;
        smem[3] = 13'd8191; emem[3] = 13'd1;
        smem[4] = 13'd8190;
        smem[6] = 13'd2;
        e_deg = 3; e_lead = 1; e_zp = 0;
        run_job(100, 758, 0);

        clr_src(3329);
        smem[0] = 13'd1; emem[0] = 13'd1;
        smem[1] = 13'd2; emem[1] = 13'd2;
        e_deg = 1; e_lead = 2; e_zp = 0;
        run_job(759, 0, 0);

        run_job(0, 0, 300);

        clr_src(3329);
        smem[0] = 13'd8191; emem[0] = 13'd3328;
        smem[756] = 13'd3330; emem[756] = 13'd1;
        e_deg = 756; e_lead = 1; e_zp = 0;
        run_job(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
